stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per one-second tick (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port btn_start_stop  input  1  asynchronous level button; each rising edge toggles run/pause.
REQ-005 SHALL have port btn_clear  input  1  asynchronous level button; each rising edge clears the stopwatch.
REQ-006 SHALL have port count_min  input  1  from seconds counter; high while seconds == 59.
REQ-007 SHALL have port enable_sc  output  1  one-cycle pulse that advances the seconds counter.
REQ-008 SHALL have port count_rst  output  1  one-cycle pulse that clears the seconds counter.
REQ-009 SHALL have port minutes  output  6  minutes count, 0..59.
REQ-010 SHALL have port running  output  1  high while the FSM is in RUN.
REQ-011 SHALL have port hour_tick  output  1  one-cycle pulse on the minutes 59->0 wrap.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; the internal event pulse occurs 3 clk edges after the input rises.
REQ-013 FSM states SHALL be IDLE, RUN and PAUSE.
REQ-014 Start/stop event: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-015 Clear event from any state SHALL go to IDLE.
REQ-016 On clear, count_rst SHALL be high for exactly the following cycle, and minutes and the prescaler SHALL be zeroed in that same cycle.
REQ-017 If clear and start/stop events coincide, clear SHALL win and start/stop SHALL be discarded.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 only in RUN.
REQ-019 When the prescaler equals TICK_DIV-1, it SHALL wrap to 0 and enable_sc SHALL be high for that one cycle.
REQ-020 The first enable_sc after IDLE->RUN SHALL occur TICK_DIV cycles after entering RUN.
REQ-021 In PAUSE the prescaler SHALL hold its value, so resuming completes the partial second.
REQ-022 enable_sc and count_rst SHALL never be high in the same cycle; count_rst suppresses enable_sc.
REQ-023 When enable_sc && count_min, minutes SHALL increment on that edge.
REQ-024 When minutes == 59 on that edge, minutes SHALL wrap to 0 and hour_tick SHALL pulse for that one cycle.
REQ-025 minutes SHALL not change in IDLE or PAUSE except on clear.
REQ-026 running SHALL be a registered decode of state == RUN.

Reset
REQ-027 On rst_n low, the following SHALL reset asynchronously: state=IDLE, prescaler=0, minutes=0, enable_sc=0, count_rst=0, hour_tick=0, running=0, and all synchronizer and edge flops =0.
REQ-028 A button held high through reset release SHALL NOT generate an event.
REQ-029 Reset mid-RUN SHALL discard any partial second.

Structure
REQ-030 A shared package stopwatch_pkg SHALL hold the state encoding (IDLE/RUN/PAUSE), MAX_MIN=59 and the minutes width 6.
REQ-031 Sub-module edge_sync (2-flop synchronizer plus rising-edge pulse) SHALL be instantiated once per button.
REQ-032 The prescaler width SHALL be $clog2(TICK_DIV).

Verification (TICK_DIV=4)
REQ-033 Reset, then raise btn_start_stop at cycle 0 -> running=1 at cycle 4; enable_sc pulses at cycles 7, 11, 15.
REQ-034 Pause after 2 prescaler counts, hold 10 cycles, then resume -> first enable_sc arrives 2 cycles after resume; no pulses while paused.
REQ-035 Hold count_min=1 for 60 ticks -> minutes steps 0..59 and then 0; hour_tick pulses once, coincident with the wrap.
REQ-036 btn_clear and btn_start_stop rise in the same cycle while in RUN -> state IDLE, count_rst is a single pulse, minutes=0, running=0, and enable_sc=0 in that cycle.
REQ-037 Assert rst_n low mid-RUN with minutes=5 and a button held high through release -> all outputs 0 immediately; no event after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch controller: FSM encoding and minutes range.
package stopwatch_pkg;

  localparam int MIN_W = 6;
  localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus registered rising-edge pulse; pulse is high 3 clk edges after input rises.
// Never fires for a level already high when reset is released; it must first be seen low.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic       r_armed;
  logic       r_pulse;
  logic [1:0] r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      // r_vld[1] marks r_s2 as holding a genuine post-reset sample
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & ~r_s2);
      r_pulse <= r_armed & r_s2 & ~r_s3;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button FSM (IDLE/RUN/PAUSE), one-second prescaler, minutes counter.
// All outputs are registered; button events act 3 edges after the button rises.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_start_stop,
  input  logic             btn_clear,
  input  logic             count_min,
  output logic             enable_sc,
  output logic             count_rst,
  output logic [MIN_W-1:0] minutes,
  output logic             running,
  output logic             hour_tick
);

  localparam int              PRE_W   = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic             w_ss_evt;
  logic             w_clr_evt;
  logic [1:0]       w_state_nxt;
  logic [PRE_W-1:0] w_presc_nxt;

  logic [1:0]       r_state;
  logic [PRE_W-1:0] r_presc;
  logic [MIN_W-1:0] r_minutes;
  logic             r_enable_sc;
  logic             r_count_rst;
  logic             r_running;
  logic             r_hour_tick;

  edge_sync u_sync_ss (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_start_stop),
    .o_pulse (w_ss_evt)
  );

  edge_sync u_sync_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_clear),
    .o_pulse (w_clr_evt)
  );

  // Clear outranks start/stop; a coincident start/stop is dropped.
  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_evt) begin
      w_state_nxt = ST_IDLE;
    end else if (w_ss_evt) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_presc_nxt = r_presc;
    if (w_clr_evt) begin
      w_presc_nxt = '0;
    end else if (r_state == ST_RUN) begin
      w_presc_nxt = (r_presc == PRE_MAX) ? '0 : r_presc + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_minutes   <= '0;
      r_enable_sc <= 1'b0;
      r_count_rst <= 1'b0;
      r_running   <= 1'b0;
      r_hour_tick <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      // Look ahead one edge so enable_sc is high exactly while the prescaler sits at its max in RUN
      r_enable_sc <= (w_state_nxt == ST_RUN) && (w_presc_nxt == PRE_MAX);
      r_count_rst <= w_clr_evt;
      r_running   <= (w_state_nxt == ST_RUN);
      r_hour_tick <= 1'b0;
      if (w_clr_evt) begin
        r_minutes <= '0;
      end else if (r_enable_sc && count_min) begin
        if (r_minutes == MAX_MIN) begin
          r_minutes   <= '0;
          r_hour_tick <= 1'b1;
        end else begin
          r_minutes <= r_minutes + MIN_W'(1);
        end
      end
    end
  end

  assign enable_sc = r_enable_sc;
  assign count_rst = r_count_rst;
  assign minutes   = r_minutes;
  assign running   = r_running;
  assign hour_tick = r_hour_tick;

endmodule
